// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard of in-flight register writes driving the ID stall.
// Optional macro HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter (o_stall_cycles).

module hazard_cnt_cell #(
  parameter int LAT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  output logic [LAT_W-1:0] o_cnt
);
  logic [LAT_W-1:0] cnt_d, cnt_q;

  // A new writer overrides the countdown so the youngest producer wins.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_hold) begin
      if (i_load)             cnt_d = i_lat;
      else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int MAX_LAT  = 4,
  parameter int LAT_W    = $clog2(MAX_LAT + 1),
  parameter int EX_SLACK = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_id_valid,
  input  logic                i_id_kill,
  input  logic                i_freeze,
  input  logic [REG_W-1:0]    i_rs,
  input  logic [REG_W-1:0]    i_rt,
  input  logic                i_rs_used,
  input  logic                i_rt_used,
  input  logic [1:0]          i_jump_type,
  input  logic [REG_W-1:0]    i_rd,
  input  logic                i_wr_en,
  input  logic [LAT_W-1:0]    i_lat,
  output logic                o_stall,
  output logic [NUM_REGS-1:0] o_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         o_stall_cycles
`endif
);
  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] SLACK_C   = LAT_W'(EX_SLACK);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            ld_hit;
  logic [LAT_W-1:0]               rs_cnt, rt_cnt, lat_clamp;
  logic                           rs_br, rt_chk, rt_br;
  logic                           rs_haz, rt_haz, issue;

  always_comb begin
    rs_br  = 1'b0;
    rt_br  = 1'b0;
    rt_chk = 1'b1;
    case (i_jump_type)
      2'b01:   begin rs_br = 1'b1; rt_br = 1'b1; end
      2'b10:   begin rs_br = 1'b1; rt_chk = 1'b0; end
      default: ;
    endcase
    rs_cnt = cnt[i_rs];
    rt_cnt = cnt[i_rt];
    // Branch operands are read in ID, so any pending write hazards; others can use EX forwarding.
    rs_haz = i_rs_used && (i_rs != '0) &&
             (rs_br ? (rs_cnt != '0) : (rs_cnt > SLACK_C));
    rt_haz = rt_chk && i_rt_used && (i_rt != '0) &&
             (rt_br ? (rt_cnt != '0) : (rt_cnt > SLACK_C));
    o_stall   = i_id_valid && !i_id_kill && (rs_haz || rt_haz);
    issue     = i_id_valid && !i_id_kill && !o_stall && !i_freeze;
    lat_clamp = (i_lat > MAX_LAT_C) ? MAX_LAT_C : i_lat;
  end

  assign cnt[0]    = '0;
  assign ld_hit[0] = 1'b0;
  assign o_busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    assign ld_hit[r] = issue && i_wr_en && (i_rd == REG_W'(r));
    hazard_cnt_cell #(.LAT_W(LAT_W)) u_cell (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_hold (i_freeze),
      .i_load (ld_hit[r]),
      .i_lat  (lat_clamp),
      .o_cnt  (cnt[r])
    );
    assign o_busy[r] = (cnt[r] != '0);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_d, stall_cycles_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (o_stall && !i_freeze && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cycles_q <= '0;
    else          stall_cycles_q <= stall_cycles_d;
  end

  assign o_stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus pushes expected stall/busy per cycle, a negedge monitor pops and compares.

module tb_hazard_scoreboard;
  logic        clk, rst_n;
  logic        id_valid, id_kill, freeze;
  logic [4:0]  rs, rt, rd;
  logic        rs_used, rt_used, wr_en;
  logic [1:0]  jump_type;
  logic [2:0]  lat;
  logic        stall;
  logic [31:0] busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_id_valid (id_valid),
    .i_id_kill  (id_kill),
    .i_freeze   (freeze),
    .i_rs       (rs),
    .i_rt       (rt),
    .i_rs_used  (rs_used),
    .i_rt_used  (rt_used),
    .i_jump_type(jump_type),
    .i_rd       (rd),
    .i_wr_en    (wr_en),
    .i_lat      (lat),
    .o_stall    (stall),
    .o_busy     (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st;
    logic [31:0] m;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (stall !== e.st) begin
        bad++;
        $display("FAIL %s stall: got %0b want %0b", e.nm, stall, e.st);
      end
      total++;
      if ((busy & e.m) !== e.v) begin
        bad++;
        $display("FAIL %s busy: got %h want %h (mask %h)", e.nm, busy & e.m, e.v, e.m);
      end
    end
  end

  function automatic logic [31:0] bm(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  task automatic drv(input logic v, input logic k, input logic f,
                     input logic [4:0] s1, input logic u1,
                     input logic [4:0] s2, input logic u2,
                     input logic [1:0] jt, input logic [4:0] d,
                     input logic we, input logic [2:0] l);
    id_valid = v; id_kill = k; freeze = f;
    rs = s1; rs_used = u1; rt = s2; rt_used = u2;
    jump_type = jt; rd = d; wr_en = we; lat = l;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic wr(input logic [4:0] d, input logic [2:0] l);
    drv(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, d, 1'b1, l);
  endtask

  task automatic chk(input string nm, input logic st, input logic [31:0] m, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.st = st; e.m = m; e.v = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("reset_state", 1'b0, 32'hFFFF_FFFF, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Load-use: LW r5 lat2, then ADD r6 <- r5 stalls once
    wr(5'd5, 3'd2);                       chk("lu_lw", 1'b0, bm(5), 32'h0); tick();
    drv(1,0,0, 5'd5,1, 5'd0,0, 2'b00, 5'd6,1, 3'd2);
    chk("lu_stall", 1'b1, bm(5)|bm(6), bm(5)); tick();
    chk("lu_issue", 1'b0, bm(5)|bm(6), bm(5)); tick();
    idle(); chk("lu_clear", 1'b0, bm(5)|bm(6), bm(6)); tick();
    tick(); tick();
    chk("lu_drain", 1'b0, 32'hFFFF_FFFF, 32'h0); tick();

    // BEQ after ALU (1 stall) and after load (2 stalls)
    wr(5'd3, 3'd1); tick();
    drv(1,0,0, 5'd3,1, 5'd4,1, 2'b01, 5'd0,0, 3'd0);
    chk("beq_alu_s1", 1'b1, bm(3), bm(3)); tick();
    chk("beq_alu_go", 1'b0, bm(3), 32'h0); tick();
    wr(5'd3, 3'd2); tick();
    drv(1,0,0, 5'd3,1, 5'd4,1, 2'b01, 5'd0,0, 3'd0);
    chk("beq_lw_s1", 1'b1, bm(3), bm(3)); tick();
    chk("beq_lw_s2", 1'b1, bm(3), bm(3)); tick();
    chk("beq_lw_go", 1'b0, bm(3), 32'h0); tick();
    drv(1,0,0, 5'd8,1, 5'd9,1, 2'b01, 5'd0,0, 3'd0);
    chk("beq_free", 1'b0, 32'hFFFF_FFFF, 32'h0); tick();

    // JR after load: stall follows Rs; Rt is not a JR source
    wr(5'd31, 3'd2); tick();
    drv(1,0,0, 5'd31,1, 5'd31,1, 2'b10, 5'd0,0, 3'd0);
    chk("jr_s1", 1'b1, bm(31), bm(31)); tick();
    chk("jr_s2", 1'b1, bm(31), bm(31)); tick();
    chk("jr_go", 1'b0, bm(31), 32'h0); tick();
    wr(5'd12, 3'd2); tick();
    drv(1,0,0, 5'd2,1, 5'd12,1, 2'b10, 5'd0,0, 3'd0);
    chk("jr_rt_only", 1'b0, bm(12), bm(12)); tick();
    // Reserved jump type behaves as a normal consumer
    wr(5'd13, 3'd2); tick();
    drv(1,0,0, 5'd13,1, 5'd0,0, 2'b11, 5'd0,0, 3'd0);
    chk("jt11_s1", 1'b1, bm(13), bm(13)); tick();
    chk("jt11_go", 1'b0, bm(13), bm(13)); tick();
    idle(); tick(); tick();

    // WAW: newer ADD r7 lat1 overrides LW r7 lat3
    wr(5'd7, 3'd3); tick();
    wr(5'd7, 3'd1); chk("waw_issue", 1'b0, bm(7), bm(7)); tick();
    idle(); chk("waw_cnt1", 1'b0, bm(7), bm(7)); tick();
    chk("waw_done", 1'b0, bm(7), 32'h0); tick();
    // Clamp: lat 7 loads MAX_LAT=4
    wr(5'd10, 3'd7); tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clamp_busy%0d", i), 1'b0, bm(10), bm(10)); tick();
    end
    chk("clamp_clear", 1'b0, bm(10), 32'h0); tick();

    // Freeze holds counters while the consumer keeps stalling
    wr(5'd9, 3'd2); tick();
    drv(1,0,1, 5'd9,1, 5'd0,0, 2'b00, 5'd11,1, 3'd2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz_%0d", i), 1'b1, bm(9)|bm(11), bm(9)); tick();
    end
    freeze = 1'b0;
    chk("frz_held", 1'b1, bm(9)|bm(11), bm(9)); tick();
    chk("frz_go", 1'b0, bm(9)|bm(11), bm(9)); tick();
    idle(); chk("frz_after", 1'b0, bm(9)|bm(11), bm(11)); tick();
    drv(1,0,1, 5'd0,0, 5'd0,0, 2'b00, 5'd14,1, 3'd2);
    chk("frz_noissue", 1'b0, bm(14), 32'h0); tick();
    idle(); chk("frz_nowrite", 1'b0, bm(14), 32'h0); tick();
    tick(); tick();

    // Kill suppresses both stall and write
    wr(5'd15, 3'd2); tick();
    drv(1,1,0, 5'd15,1, 5'd0,0, 2'b00, 5'd16,1, 3'd2);
    chk("kill_nostall", 1'b0, bm(15)|bm(16), bm(15)); tick();
    idle(); chk("kill_nowrite", 1'b0, bm(16), 32'h0); tick();
    tick(); tick();

    // Asynchronous reset with entries pending
    wr(5'd20, 3'd4); tick();
    wr(5'd21, 3'd3); tick();
    drv(1,0,0, 5'd20,1, 5'd0,0, 2'b00, 5'd0,0, 3'd0);
    chk("pre_rst", 1'b1, bm(20)|bm(21), bm(20)|bm(21)); tick();
    rst_n = 1'b0;
    chk("rst_async", 1'b0, 32'hFFFF_FFFF, 32'h0); tick();
    rst_n = 1'b1;
    chk("post_rst", 1'b0, 32'hFFFF_FFFF, 32'h0); tick();

    // r0 is never tracked
    wr(5'd0, 3'd3); tick();
    drv(1,0,0, 5'd0,1, 5'd0,1, 2'b01, 5'd0,0, 3'd0);
    chk("r0_beq", 1'b0, 32'hFFFF_FFFF, 32'h0); tick();
    drv(1,0,0, 5'd0,1, 5'd0,1, 2'b00, 5'd0,0, 3'd0);
    chk("r0_alu", 1'b0, 32'hFFFF_FFFF, 32'h0); tick();
    idle(); tick(); tick();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, sequential successor to the pipeline's combinational hazard detector.
- Keeps a per-register countdown scoreboard of in-flight writes with variable result latency (ALU, load, multi-cycle ops).
- Drives the IF/ID stall for the instruction currently in ID.
- Sits beside the decode stage. Replaces stage-by-stage Rd comparison with a single latency model that covers load-use, branch-in-ID and JR/JALR hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- REG_W, $clog2(NUM_REGS), register address width.
- MAX_LAT, 4, largest accepted producer latency; larger requests clamp to MAX_LAT.
- LAT_W, $clog2(MAX_LAT+1), counter width.
- EX_SLACK, 1, cycles of latency hidden by EX-stage forwarding for non-branch consumers.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_kill  in  1  ID instruction squashed (taken branch or jump); it is not issued
- i_freeze  in  1  global pipeline freeze (memory wait or debug); scoreboard holds
- i_rs  in  REG_W  source register Rs of the ID instruction
- i_rt  in  REG_W  source register Rt of the ID instruction
- i_rs_used  in  1  ID instruction reads Rs
- i_rt_used  in  1  ID instruction reads Rt
- i_jump_type  in  2  00 none, 01 BEQ/BNE (Rs and Rt compared in ID), 10 JR/JALR (Rs read in ID), 11 reserved (treated as 00)
- i_rd  in  REG_W  destination register of the ID instruction
- i_wr_en  in  1  ID instruction writes i_rd
- i_lat  in  LAT_W  cycles until the result is readable in ID (regfile or ID forward path)
- o_stall  out  1  hold PC and IF/ID and inject an ID/EX bubble
- o_busy  out  NUM_REGS  bit r set while cnt[r] != 0

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Reset (async, i_rst_n=0): all cnt = 0, so o_busy = 0 and o_stall = 0. Reset mid-operation discards all pending entries immediately.
- Per-source need: src_need(s) = used(s) && s != 0.
- Branch consumer (jump_type 01, sources Rs and Rt; jump_type 10, source Rs only): hazard if cnt[s] != 0.
- Normal consumer (jump_type 00 or 11): hazard if cnt[s] > EX_SLACK.
- o_stall = i_id_valid && !i_id_kill && any hazard. It is combinational from the current state and inputs, with no cycle of latency.
- issue = i_id_valid && !i_id_kill && !o_stall && !i_freeze.
- Per-cycle update, when i_freeze = 0:
  - every cnt[r] != 0 decrements by 1;
  - then, if issue && i_wr_en && i_rd != 0, cnt[i_rd] <= min(i_lat, MAX_LAT). This overrides the decrement, so the newest writer wins (WAW).
- i_lat = 0: entry stays 0 (result already forwardable).
- When i_freeze = 1: all cnt hold and no issue occurs. o_stall is still evaluated and driven.
- Self-dependence (i_rs == i_rd): the source is checked against the pre-update state, so the instruction never stalls on itself.
- Counters never wrap: decrement only from nonzero, and load values are clamped.
- While stalled, the ID instruction re-evaluates every cycle. It issues in the first cycle its hazards clear and i_freeze = 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - adds output o_stall_cycles, out, 32 bits;
  - the counter increments each cycle o_stall = 1 && i_freeze = 0;
  - it saturates at 0xFFFFFFFF and resets to 0.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Load-use: issue LW r5 (lat=2), then ADD using r5 (jump_type 00). Required: o_stall=1 for exactly 1 cycle, ADD issues in the next cycle, and o_busy[5] clears 2 cycles after the LW issues.
- Branch after ALU: ADD r3 (lat=1), then BEQ r3,r4. Required: 1 stall cycle. Same BEQ after LW r3 (lat=2): 2 stall cycles. BEQ with no pending producer: 0 stalls.
- JR after load: LW r31 (lat=2), then JR r31 with rt_used=1 and rt=r31 pending. Required: 2 stalls, driven by Rs only. JR with only Rt pending: 0 stalls.
- WAW and clamp: LW r7 lat=3, then ADD r7 lat=1 on the next cycle. Required: cnt[7]=1 after the second issue. i_lat=7 with MAX_LAT=4: cnt loads 4.
- Freeze and kill: set cnt[9]=2 and assert i_freeze for 3 cycles. Required: cnt[9] stays 2 and o_stall stays asserted for the consumer. i_id_kill=1 with a hazard present: o_stall=0 and no entry is written.
- Reset and r0: assert i_rst_n=0 with several entries pending. Required: o_busy=0 and o_stall=0 immediately. An instruction writing r0 (lat=3) never sets o_busy[0], and a later reader of r0 never stalls.
